// File: rtl/controller_poll_scheduler.sv
// controller_poll_scheduler: latch/clock sequencer that reads both NES controller ports per poll.
// Optional CONTROLLER_POLL_DEBOUNCE_EN: publish a port only when two consecutive samples agree.
module controller_poll_scheduler #(
  parameter int LATCH_CYCLES       = 2,
  parameter int HALF_PERIOD_CYCLES = 1,
  parameter int NUM_BUTTONS        = 8
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       poll_start,
  output logic       controller_latch,
  output logic       controller_clk_out,
  input  logic       controller_1_data_in_B,
  input  logic       controller_2_data_in_B,
  output logic [7:0] controller_1_buttons_out,
  output logic [7:0] controller_2_buttons_out,
  output logic       busy,
  output logic       poll_done
);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } state_t;

  localparam int TMAX = (LATCH_CYCLES > HALF_PERIOD_CYCLES)
                      ? LATCH_CYCLES : HALF_PERIOD_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_PERIOD_CYCLES - 1);
  localparam logic [3:0]    NB         = 4'(NUM_BUTTONS);

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    sh1, sh1_nx;
  logic [7:0]    sh2, sh2_nx;
  logic          pending, pending_nx;
  logic          start_poll;
  logic [2:0]    idx;

  // Bits land left-aligned, first received in bit 7.
  assign idx = 3'(4'd7 - bit_cnt);

  always_comb begin
    state_nx   = state;
    timer_nx   = timer + 1'b1;
    bit_cnt_nx = bit_cnt;
    sh1_nx     = sh1;
    sh2_nx     = sh2;
    pending_nx = pending | poll_start;
    start_poll = 1'b0;
    unique case (state)
      IDLE: begin
        timer_nx   = '0;
        pending_nx = 1'b0;
        if (poll_start) begin
          state_nx   = LATCH;
          start_poll = 1'b1;
        end
      end
      LATCH: begin
        if (timer == LATCH_LAST) begin
          state_nx = CLK_LOW;
          timer_nx = '0;
        end
      end
      CLK_LOW: begin
        if (timer == HALF_LAST) begin
          sh1_nx[idx] = ~controller_1_data_in_B;
          sh2_nx[idx] = ~controller_2_data_in_B;
          state_nx    = CLK_HIGH;
          timer_nx    = '0;
        end
      end
      CLK_HIGH: begin
        if (timer == HALF_LAST) begin
          timer_nx   = '0;
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt + 4'd1 == NB) state_nx = DONE;
          else                      state_nx = CLK_LOW;
        end
      end
      DONE: begin
        timer_nx   = '0;
        pending_nx = 1'b0;
        // A request arriving now, or held earlier, restarts with no idle gap.
        if (pending || poll_start) begin
          state_nx   = LATCH;
          start_poll = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
    if (start_poll) begin
      bit_cnt_nx = '0;
      sh1_nx     = '0;
      sh2_nx     = '0;
    end
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state              <= IDLE;
      timer              <= '0;
      bit_cnt            <= '0;
      sh1                <= '0;
      sh2                <= '0;
      pending            <= 1'b0;
      controller_latch   <= 1'b0;
      controller_clk_out <= 1'b0;
      busy               <= 1'b0;
      poll_done          <= 1'b0;
    end else begin
      state              <= state_nx;
      timer              <= timer_nx;
      bit_cnt            <= bit_cnt_nx;
      sh1                <= sh1_nx;
      sh2                <= sh2_nx;
      pending            <= pending_nx;
      controller_latch   <= (state_nx == LATCH);
      controller_clk_out <= (state_nx == CLK_HIGH);
      busy               <= (state_nx != IDLE);
      poll_done          <= (state_nx == DONE);
    end
  end

`ifdef CONTROLLER_POLL_DEBOUNCE_EN
  logic [7:0] raw1, raw2;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      raw1                     <= '0;
      raw2                     <= '0;
      controller_1_buttons_out <= '0;
      controller_2_buttons_out <= '0;
    end else if (state_nx == DONE) begin
      raw1 <= sh1;
      raw2 <= sh2;
      if (sh1 == raw1) controller_1_buttons_out <= sh1;
      if (sh2 == raw2) controller_2_buttons_out <= sh2;
    end
  end
`else
  always_ff @(posedge clk_1) begin
    if (rst) begin
      controller_1_buttons_out <= '0;
      controller_2_buttons_out <= '0;
    end else if (state_nx == DONE) begin
      controller_1_buttons_out <= sh1;
      controller_2_buttons_out <= sh2;
    end
  end
`endif

endmodule

// File: tb/tb_controller_poll_scheduler.sv
// tb_controller_poll_scheduler: directed polls on three parameterisations.
// Controller model shifts a pattern out MSB-first on each clk_out rising edge.
module tb_controller_poll_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [3];
  logic       lat   [3];
  logic       ck    [3];
  logic       d1    [3];
  logic       d2    [3];
  logic       busy  [3];
  logic       done  [3];
  logic [7:0] b1    [3];
  logic [7:0] b2    [3];
  logic [7:0] pat1  [3];
  logic [7:0] pat2  [3];
  logic [7:0] m1    [3];
  logic [7:0] m2    [3];
  logic [7:0] r1    [3];
  logic [7:0] r2    [3];

  logic [7:0] p1s [3] = '{8'h0F, 8'hF0, 8'hF0};
  logic [7:0] p2s [3] = '{8'hF0, 8'h0F, 8'h0F};
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
  logic [7:0] e1s [3] = '{8'h00, 8'h00, 8'hF0};
  logic [7:0] e2s [3] = '{8'h00, 8'h00, 8'h0F};
`else
  logic [7:0] e1s [3] = '{8'h0F, 8'hF0, 8'hF0};
  logic [7:0] e2s [3] = '{8'hF0, 8'h0F, 8'h0F};
`endif

  int checks = 0;
  int errors = 0;

  controller_poll_scheduler dut0 (
    .clk_1(clk), .rst(rst), .poll_start(start[0]),
    .controller_latch(lat[0]), .controller_clk_out(ck[0]),
    .controller_1_data_in_B(d1[0]), .controller_2_data_in_B(d2[0]),
    .controller_1_buttons_out(b1[0]), .controller_2_buttons_out(b2[0]),
    .busy(busy[0]), .poll_done(done[0])
  );

  controller_poll_scheduler #(
    .LATCH_CYCLES(3), .HALF_PERIOD_CYCLES(2), .NUM_BUTTONS(8)
  ) dut1 (
    .clk_1(clk), .rst(rst), .poll_start(start[1]),
    .controller_latch(lat[1]), .controller_clk_out(ck[1]),
    .controller_1_data_in_B(d1[1]), .controller_2_data_in_B(d2[1]),
    .controller_1_buttons_out(b1[1]), .controller_2_buttons_out(b2[1]),
    .busy(busy[1]), .poll_done(done[1])
  );

  controller_poll_scheduler #(
    .LATCH_CYCLES(1), .HALF_PERIOD_CYCLES(1), .NUM_BUTTONS(3)
  ) dut2 (
    .clk_1(clk), .rst(rst), .poll_start(start[2]),
    .controller_latch(lat[2]), .controller_clk_out(ck[2]),
    .controller_1_data_in_B(d1[2]), .controller_2_data_in_B(d2[2]),
    .controller_1_buttons_out(b1[2]), .controller_2_buttons_out(b2[2]),
    .busy(busy[2]), .poll_done(done[2])
  );

  for (genvar g = 0; g < 3; g++) begin : mdl
    logic [3:0] k  = 4'd0;
    logic       pc = 1'b0;
    always @(posedge clk) begin
      pc <= ck[g];
      if (lat[g])           k <= 4'd0;
      else if (ck[g] && !pc) k <= k + 4'd1;
    end
    assign d1[g] = (k < 4'd8) ? ~pat1[g][3'(7 - k)] : 1'b0;
    assign d2[g] = (k < 4'd8) ? ~pat2[g][3'(7 - k)] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 3; i++) begin
      m1[i] = 8'h00; m2[i] = 8'h00;
      r1[i] = 8'h00; r2[i] = 8'h00;
    end
  endtask

  task automatic mdl_poll(input int s, input logic [7:0] mask);
    logic [7:0] x1, x2;
    x1 = pat1[s] & mask;
    x2 = pat2[s] & mask;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
    if (x1 == r1[s]) m1[s] = x1;
    if (x2 == r2[s]) m2[s] = x2;
    r1[s] = x1;
    r2[s] = x2;
`else
    m1[s] = x1;
    m2[s] = x2;
`endif
  endtask

  // Issues poll_start at cycle 0, optional extra requests at cycles x1/x2.
  task automatic run_poll(input int s, input int x1, input int x2,
                          input int ndone, input int maxc,
                          output int tf, output int tl, output int nl,
                          output int nr, output int bad);
    int   n    = 0;
    int   seen = 0;
    logic pck  = 1'b0;
    tf = -1; tl = -1; nl = 0; nr = 0; bad = 0;
    @(negedge clk);
    start[s] = 1'b1;
    while (seen < ndone && n < maxc) begin
      @(negedge clk);
      n++;
      start[s] = (n == x1 || n == x2);
      if (lat[s]) nl++;
      if (ck[s] && !pck) nr++;
      pck = ck[s];
      if (lat[s] && ck[s]) bad++;
      if (!busy[s]) bad++;
      if (tf < 0 && !done[s] && (b1[s] !== m1[s] || b2[s] !== m2[s])) bad++;
      if (done[s]) begin
        seen++;
        if (tf < 0) tf = n;
        tl = n;
      end
    end
    start[s] = 1'b0;
    if (seen < ndone) chk("timeout", seen, ndone);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int tf, tl, nl, nr, bad, nb;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; pat1[i] = 8'h00; pat2[i] = 8'h00;
    end
    mdl_reset();
    repeat (2) @(negedge clk);
    chk("rst_latch", lat[0], 0);
    chk("rst_clk", ck[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_b1", b1[0], 8'h00);
    chk("rst_b2", b2[0], 8'h00);
    rst = 1'b0;

    pat1[0] = 8'h80; pat2[0] = 8'h01;
    run_poll(0, -1, -1, 1, 60, tf, tl, nl, nr, bad);
    mdl_poll(0, 8'hFF);
    chk("p1_done_cyc", tf, 19);
    chk("p1_latch_n", nl, 2);
    chk("p1_rises", nr, 8);
    chk("p1_bad", bad, 0);
    chk("p1_b1", b1[0], m1[0]);
    chk("p1_b2", b2[0], m2[0]);
    @(negedge clk);
    chk("p1_done_pulse", done[0], 0);
    chk("p1_idle", busy[0], 0);

    pat1[0] = 8'h5A; pat2[0] = 8'hC3;
    run_poll(0, 5, 8, 2, 90, tf, tl, nl, nr, bad);
    mdl_poll(0, 8'hFF);
    mdl_poll(0, 8'hFF);
    chk("b2b_first", tf, 19);
    chk("b2b_second", tl, 38);
    chk("b2b_latch_n", nl, 4);
    chk("b2b_rises", nr, 16);
    chk("b2b_bad", bad, 0);
    chk("b2b_b1", b1[0], m1[0]);
    chk("b2b_b2", b2[0], m2[0]);
    nb = 0;
    repeat (25) begin
      @(negedge clk);
      if (done[0] || busy[0]) nb++;
    end
    chk("b2b_merged", nb, 0);

    pat1[0] = 8'h81; pat2[0] = 8'h7E;
    run_poll(0, 19, -1, 2, 90, tf, tl, nl, nr, bad);
    mdl_poll(0, 8'hFF);
    mdl_poll(0, 8'hFF);
    chk("atdone_second", tl, 38);
    chk("atdone_bad", bad, 0);
    chk("atdone_b1", b1[0], m1[0]);
    chk("atdone_b2", b2[0], m2[0]);

    pat1[1] = 8'hA5; pat2[1] = 8'h5A;
    run_poll(1, -1, -1, 1, 90, tf, tl, nl, nr, bad);
    mdl_poll(1, 8'hFF);
    chk("par_done_cyc", tf, 36);
    chk("par_latch_n", nl, 3);
    chk("par_rises", nr, 8);
    chk("par_bad", bad, 0);
    chk("par_b1", b1[1], m1[1]);
    chk("par_b2", b2[1], m2[1]);

    pat1[2] = 8'hA5; pat2[2] = 8'h5A;
    run_poll(2, -1, -1, 1, 40, tf, tl, nl, nr, bad);
    mdl_poll(2, 8'hE0);
    chk("n3_done_cyc", tf, 8);
    chk("n3_latch_n", nl, 1);
    chk("n3_rises", nr, 3);
    chk("n3_bad", bad, 0);
    chk("n3_b1", b1[2], m1[2]);
    chk("n3_b2", b2[2], m2[2]);

    pat1[0] = 8'h3C; pat2[0] = 8'hC3;
    @(negedge clk);
    start[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start[0] = (n == 5);
    end
    chk("mid_clk4", ck[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    chk("mid_b1", b1[0], 8'h00);
    chk("mid_b2", b2[0], 8'h00);
    chk("mid_busy", busy[0], 0);
    chk("mid_latch", lat[0], 0);
    chk("mid_clk", ck[0], 0);
    chk("mid_done", done[0], 0);
    nb = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy[0]) nb++;
    end
    chk("mid_no_pending", nb, 0);
    run_poll(0, -1, -1, 1, 60, tf, tl, nl, nr, bad);
    mdl_poll(0, 8'hFF);
    chk("fresh_done_cyc", tf, 19);
    chk("fresh_bad", bad, 0);
    chk("fresh_b1", b1[0], m1[0]);
    chk("fresh_b2", b2[0], m2[0]);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    for (int i = 0; i < 3; i++) begin
      pat1[0] = p1s[i]; pat2[0] = p2s[i];
      run_poll(0, -1, -1, 1, 60, tf, tl, nl, nr, bad);
      mdl_poll(0, 8'hFF);
      chk("deb_done_cyc", tf, 19);
      chk("deb_b1", b1[0], e1s[i]);
      chk("deb_b2", b2[0], e2s[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
